alu_bist_sequencer: RTL and testbench

On-chip stimulus/response engine for the 4-bit ALU user project: drives the ALU's `ui_in`/`uio_in` pins from an internal vector counter and compresses the ALU's `uo_out` into a 16-bit MISR signature. It is the driving end of the pin interface the cocotb bench exercises today, so the ALU can be self-tested in silicon without an external tester. On completion it compares the signature against a parameterised golden value and reports pass/fail.

---
 rtl/alu_bist_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_bist_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_sequencer.sv
// Built-in self-test sequencer for the 4-bit ALU: sweeps every {op, A, B} vector on the ALU
// input pins and folds each ALU result into a 16-bit MISR signature checked against a golden value.
module alu_bist_sequencer #(
    parameter int unsigned OPCODES    = 8,
    parameter int unsigned SETTLE     = 1,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  ui_drive,
    output logic [7:0]  uio_drive,
    input  logic [7:0]  uo_sample,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [10:0] vector_idx
);

    localparam int unsigned        CntW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0]    SettleLoad = CntW'(SETTLE - 1);
    localparam logic [10:0]        LastIdx    = 11'(OPCODES * 256 - 1);
    localparam logic [15:0]        MisrPoly   = 16'h1021;
    localparam logic [15:0]        MisrSeed   = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWait,
        StCapture,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [10:0]     k_q, k_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     misr_q, misr_d;
    logic [15:0]     misr_next;
    logic [7:0]      ui_q, ui_d;
    logic [2:0]      op_q, op_d;
    logic [10:0]     idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    always_comb begin
        misr_next = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? MisrPoly : 16'h0000)
                  ^ {8'h00, uo_sample};
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        misr_d  = misr_q;
        ui_d    = ui_q;
        op_d    = op_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            StIdle, StDone: begin
                // Drive pins keep the last vector until the new run's first APPLY.
                if (start) begin
                    state_d = StApply;
                    k_d     = 11'd0;
                    misr_d  = MisrSeed;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StApply: begin
                ui_d    = k_q[7:0];
                op_d    = k_q[10:8];
                idx_d   = k_q;
                cnt_d   = SettleLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapture: begin
                misr_d = misr_next;
                if (k_q == LastIdx) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (misr_next == GOLDEN_SIG);
                end else begin
                    k_d     = k_q + 11'd1;
                    state_d = StApply;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= 11'd0;
            cnt_q   <= '0;
            misr_q  <= MisrSeed;
            ui_q    <= 8'h00;
            op_q    <= 3'd0;
            idx_q   <= 11'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            misr_q  <= misr_d;
            ui_q    <= ui_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign ui_drive   = ui_q;
    assign uio_drive  = {5'b00000, op_q};
    assign vector_idx = idx_q;
    assign signature  = misr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Directed bench for alu_bist_sequencer: three instances (full sweep, slow settle, golden match)
// driven by a stub or modelled ALU, checked against hand values and a reference MISR model.
module tb_alu_bist_sequencer;

    function automatic logic [7:0] alu_model(input logic [10:0] k);
        logic [7:0] aa;
        logic [7:0] bb;
        logic [7:0] r;
        aa = {4'h0, k[7:4]};
        bb = {4'h0, k[3:0]};
        case (k[10:8])
            3'd0:    r = aa + bb;
            3'd1:    r = aa - bb;
            3'd2:    r = aa & bb;
            3'd3:    r = aa | bb;
            3'd4:    r = aa ^ bb;
            3'd5:    r = {4'h0, ~k[7:4]};
            3'd6:    r = aa << 1;
            default: r = aa * bb;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [7:0] u);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {8'h00, u};
    endfunction

    function automatic logic [15:0] ref_sig(input int nvec, input bit use_alu, input int flip_k);
        logic [15:0] m;
        logic [7:0]  u;
        m = 16'hFFFF;
        for (int k = 0; k < nvec; k++) begin
            u = use_alu ? alu_model(11'(k)) : 8'h00;
            if (k == flip_k) u = u ^ 8'h01;
            m = misr_step(m, u);
        end
        return m;
    endfunction

    localparam logic [15:0] RefSigC = ref_sig(256, 1'b1, -1);

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: full 8-opcode sweep, settle 1, golden left at zero.
    logic        start_a, use_alu_a;
    logic [7:0]  stub_a, ui_a, uio_a, uo_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] sig_a;
    logic [10:0] idx_a;
    assign uo_a = use_alu_a ? alu_model({uio_a[2:0], ui_a}) : stub_a;

    alu_bist_sequencer #(.OPCODES(8), .SETTLE(1), .GOLDEN_SIG(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .ui_drive(ui_a), .uio_drive(uio_a),
        .uo_sample(uo_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a), .vector_idx(idx_a)
    );

    // Instance b: two opcodes, settle 3, all-zero ALU response.
    logic        start_b;
    logic [7:0]  ui_b, uio_b, uo_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_b;
    logic [10:0] idx_b;
    assign uo_b = 8'h00;

    alu_bist_sequencer #(.OPCODES(2), .SETTLE(3), .GOLDEN_SIG(16'h0000)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .ui_drive(ui_b), .uio_drive(uio_b),
        .uo_sample(uo_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .vector_idx(idx_b)
    );

    // Instance c: one opcode, golden taken from the reference model; optional bit flip at 0x042.
    logic        start_c, flip_c;
    logic [7:0]  ui_c, uio_c, uo_c;
    logic        busy_c, done_c, pass_c;
    logic [15:0] sig_c;
    logic [10:0] idx_c;
    assign uo_c = alu_model({uio_c[2:0], ui_c})
                ^ ((flip_c && ({uio_c[2:0], ui_c} == 11'h042)) ? 8'h01 : 8'h00);

    alu_bist_sequencer #(.OPCODES(1), .SETTLE(1), .GOLDEN_SIG(RefSigC)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .ui_drive(ui_c), .uio_drive(uio_c),
        .uo_sample(uo_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .signature(sig_c), .vector_idx(idx_c)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idx_a(input logic [10:0] target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick(1);
            if (idx_a == target) hit = 1'b1;
        end
        chk("wait_idx_a", 32'(hit), 32'd1);
    endtask

    task automatic wait_done(input int which, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick(1);
            case (which)
                0:       hit = done_a;
                1:       hit = done_b;
                default: hit = done_c;
            endcase
        end
        chk("wait_done", 32'(hit), 32'd1);
    endtask

    initial begin
        int          c1;
        logic [15:0] exp_sig;

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        use_alu_a = 1'b0; stub_a = 8'h00; flip_c = 1'b0;
        tick(2);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_sig", 32'(sig_a), 32'hFFFF);
        chk("rst_ui", 32'(ui_a), 32'h00);
        chk("rst_uio", 32'(uio_a), 32'h00);
        chk("rst_idx", 32'(idx_a), 32'h000);

        // First vector timing and MISR with zero response
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk("start_busy", 32'(busy_a), 32'd1);
        tick(1);
        chk("v0_ui", 32'(ui_a), 32'h00);
        chk("v0_uio", 32'(uio_a), 32'h00);
        chk("v0_idx", 32'(idx_a), 32'h000);
        tick(1);
        chk("sig_before_capture", 32'(sig_a), 32'hFFFF);
        tick(1);
        chk("sig_zero", 32'(sig_a), 32'hEFDF);

        // Reset mid-run at k=0x123
        wait_idx_a(11'h123, 2000);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        chk("midrst_sig", 32'(sig_a), 32'hFFFF);
        chk("midrst_ui", 32'(ui_a), 32'h00);
        chk("midrst_uio", 32'(uio_a), 32'h00);
        chk("midrst_idx", 32'(idx_a), 32'h000);

        // MISR with 0x5A response
        stub_a = 8'h5A;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(3);
        chk("sig_5a", 32'(sig_a), 32'hEF85);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // Full sweep with modelled ALU
        use_alu_a = 1'b1;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        c1 = cyc;
        wait_idx_a(11'h010, 200);
        start_a = 1'b1;
        tick(3);
        start_a = 1'b0;
        chk("busy_start_idx", 32'(idx_a), 32'h011);
        chk("busy_start_sig", 32'(sig_a), 32'(ref_sig(17, 1'b1, -1)));
        wait_idx_a(11'h1A5, 2000);
        chk("map_1a5_ui", 32'(ui_a), 32'hA5);
        chk("map_1a5_uio", 32'(uio_a), 32'h01);
        wait_idx_a(11'h7FF, 6000);
        chk("map_7ff_ui", 32'(ui_a), 32'hFF);
        chk("map_7ff_uio", 32'(uio_a), 32'h07);
        wait_done(0, 100);
        chk("runlen_a", 32'(cyc - c1), 32'd6144);
        exp_sig = ref_sig(2048, 1'b1, -1);
        chk("full_sig_a", 32'(sig_a), 32'(exp_sig));
        chk("full_pass_a", 32'(pass_a), 32'(exp_sig == 16'h0000));
        chk("full_busy_a", 32'(busy_a), 32'd0);
        tick(5);
        chk("hold_done", 32'(done_a), 32'd1);
        chk("hold_ui", 32'(ui_a), 32'hFF);
        chk("hold_uio", 32'(uio_a), 32'h07);
        chk("hold_sig", 32'(sig_a), 32'(exp_sig));

        // Restart from DONE
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        c1 = cyc;
        chk("restart_done", 32'(done_a), 32'd0);
        chk("restart_busy", 32'(busy_a), 32'd1);
        chk("restart_sig", 32'(sig_a), 32'hFFFF);
        wait_done(0, 6300);
        chk("restart_runlen", 32'(cyc - c1), 32'd6144);
        chk("restart_sig_end", 32'(sig_a), 32'(exp_sig));

        // Two opcodes, settle 3
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        c1 = cyc;
        wait_done(1, 2700);
        chk("runlen_b", 32'(cyc - c1), 32'd2560);
        exp_sig = ref_sig(512, 1'b0, -1);
        chk("sig_b", 32'(sig_b), 32'(exp_sig));
        chk("pass_b", 32'(pass_b), 32'(exp_sig == 16'h0000));
        chk("last_ui_b", 32'(ui_b), 32'hFF);
        chk("last_uio_b", 32'(uio_b), 32'h01);
        chk("last_idx_b", 32'(idx_b), 32'h1FF);

        // Golden match, then a single flipped result bit
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        wait_done(2, 900);
        chk("golden_sig_c", 32'(sig_c), 32'(RefSigC));
        chk("golden_pass_c", 32'(pass_c), 32'd1);
        chk("golden_busy_c", 32'(busy_c), 32'd0);
        flip_c = 1'b1;
        start_c = 1'b1;
        tick(1);
        start_c = 1'b0;
        chk("flip_pass_cleared", 32'(pass_c), 32'd0);
        wait_done(2, 900);
        chk("flip_sig_c", 32'(sig_c), 32'(ref_sig(256, 1'b1, 32'h042)));
        chk("flip_pass_c", 32'(pass_c), 32'd0);
        chk("flip_idx_c", 32'(idx_c), 32'h0FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
